stream_input_fetcher: RTL and testbench

Single-channel memory-to-CGRA input streamer. On a start pulse it issues AXI-Lite read requests for a strided sequence of 32-bit words. It extracts the addressed 32-bit lane from each 64-bit read beat, buffers the words, and presents them to one CGRA input node over a valid/ready handshake. One instance per input node sits between the AXI-Lite master port and the CGRA data inputs; the CSR block drives its configuration and start, and consumes its done and error status.

---
 rtl/stream_fetch_pkg.sv | 7 +
 rtl/stream_input_fetcher_if.sv | 28 ++
 rtl/stream_fifo.sv | 60 ++++++
 rtl/stream_input_fetcher.sv | 134 +++++++++++++
 tb/tb_stream_input_fetcher.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fetch_pkg.sv
// Shared types and constants for the strided memory-to-CGRA input streamer.
package stream_fetch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         WORD_W    = 32;
endpackage

// File: rtl/stream_input_fetcher_if.sv
// AXI-Lite read channel plus the word stream towards one CGRA input node.
interface stream_input_fetcher_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    import stream_fetch_pkg::*;

    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_valid;
    logic                      r_ready;
    logic [WORD_W-1:0]         data;
    logic                      data_valid;
    logic                      data_ready;

    modport master (
        output ar_addr, ar_valid, r_ready, data, data_valid,
        input  ar_ready, r_data, r_resp, r_valid, data_ready
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready, data, data_valid,
        output ar_ready, r_data, r_resp, r_valid, data_ready
    );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO; head entry is read straight from the storage registers.
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i && (count_q != '0);
        // a pop frees the slot in the same cycle, so a full FIFO can still take a push
        do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/stream_input_fetcher.sv
// Issues strided AXI-Lite reads, picks the addressed 32-bit lane of each beat
// and streams the words to a CGRA input node.
module stream_input_fetcher
    import stream_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           size_i,
    input  logic [15:0]           stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    stream_input_fetcher_if.master bus
);
    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = FIFO_DEPTH[CW-1:0];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [15:0]           stride_q, stride_d;
    logic                  error_q, error_d;

    logic                  ar_valid, ar_fire, r_fire, d_fire;
    logic [CW:0]           in_flight;
    logic [WORD_W-1:0]     lane_word;
    logic [WORD_W-1:0]     word_dout;
    logic [CW-1:0]         word_count, lane_count;
    logic                  word_full, word_empty;
    logic                  lane_full, lane_empty, lane_head;
    logic                  unused_flags;

    assign unused_flags = lane_full | word_full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        stride_d    = stride_q;
        error_d     = error_q;

        // lane queue holds one entry per AR without its R beat, so its count is the outstanding count
        in_flight = {1'b0, lane_count} + {1'b0, word_count};
        ar_valid  = (state_q == RUN) && (remaining_q != 16'd0) && (in_flight < {1'b0, DEPTH_CNT});
        ar_fire   = ar_valid && bus.ar_ready;
        r_fire    = bus.r_valid && !lane_empty;
        d_fire    = !word_empty && bus.data_ready;
        lane_word = lane_head ? bus.r_data[2*WORD_W-1:WORD_W] : bus.r_data[WORD_W-1:0];

        if (r_fire && (bus.r_resp != RESP_OKAY)) error_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = size_i;
                    stride_d    = stride_i;
                    error_d     = 1'b0;
                    state_d     = (size_i != 16'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (ar_fire) begin
                    addr_d      = addr_q + {{(ADDR_WIDTH-16){1'b0}}, stride_q};
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // finish in the cycle after the last word leaves the buffer
                if (lane_empty && (word_empty || ((word_count == CW'(1)) && d_fire)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            stride_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            stride_q    <= stride_d;
            error_q     <= error_d;
        end
    end

    stream_fifo #(.WIDTH(1), .DEPTH(FIFO_DEPTH)) u_lane_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ar_fire),
        .din_i   (addr_q[2]),
        .pop_i   (r_fire),
        .dout_o  (lane_head),
        .count_o (lane_count),
        .full_o  (lane_full),
        .empty_o (lane_empty)
    );

    stream_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_word_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (r_fire),
        .din_i   (lane_word),
        .pop_i   (d_fire),
        .dout_o  (word_dout),
        .count_o (word_count),
        .full_o  (word_full),
        .empty_o (word_empty)
    );

    assign bus.ar_addr    = addr_q;
    assign bus.ar_valid   = ar_valid;
    assign bus.r_ready    = 1'b1;
    assign bus.data       = word_dout;
    assign bus.data_valid = !word_empty;

    assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
    assign done_o  = (state_q == DONE);
    assign error_o = error_q;
endmodule

// File: tb/tb_stream_input_fetcher.sv
// Directed bench: memory returns word value == byte address; a transfer-level
// model predicts every AR address, every streamed word and the status flags.
module tb_stream_input_fetcher;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base;
    logic [15:0] size, stride;
    logic        busy, done, error;

    stream_input_fetcher_if #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) bus ();

    stream_input_fetcher #(.ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .FIFO_DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base),
        .size_i      (size),
        .stride_i    (stride),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // memory / interconnect knobs, written only by the main sequence
    bit gap_mode = 1'b0;
    int err_beat = -1;

    // memory responder: one R beat per accepted AR, at least one cycle later
    logic [31:0] mem_q[$];
    int          beat_idx = 0;
    initial begin
        logic [31:0] a, b;
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_data   = '0;
        bus.r_resp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_q.delete();
                bus.r_valid  = 1'b0;
                bus.ar_ready = 1'b0;
            end else begin
                if (start && !busy && !done) beat_idx = 0;
                if (mem_q.size() != 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
                    a = mem_q.pop_front();
                    b = {a[31:3], 3'b000};
                    bus.r_data  = {b + 32'd4, b};
                    bus.r_resp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
                    bus.r_valid = 1'b1;
                    beat_idx++;
                end else begin
                    bus.r_valid = 1'b0;
                    bus.r_resp  = 2'b00;
                end
                bus.ar_ready = gap_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (bus.ar_valid && bus.ar_ready) mem_q.push_back(bus.ar_addr);
            end
        end
    end

    // transfer model: word i lives at base + i*stride and its value is that address
    logic [31:0] m_base;
    logic [15:0] m_size, m_stride;
    bit          m_busy, m_done, m_err;
    int          ar_idx, d_idx, done_cnt;
    logic [31:0] first_ar, last_ar, first_data, last_data;
    bit          prev_stall;
    logic [31:0] prev_addr;

    initial begin
        bit          nd, nb;
        logic [31:0] e;
        m_busy = 0; m_done = 0; m_err = 0; ar_idx = 0; d_idx = 0; done_cnt = 0;
        m_base = '0; m_size = '0; m_stride = '0; prev_stall = 0; prev_addr = '0;
        first_ar = '0; last_ar = '0; first_data = '0; last_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                m_busy = 0; m_done = 0; m_err = 0; ar_idx = 0; d_idx = 0;
                m_size = '0; prev_stall = 0;
            end else begin
                check("busy", busy, m_busy);
                check("done", done, m_done);
                check("error", error, m_err);
                if (done) done_cnt++;
                if (prev_stall) begin
                    check("ar_hold_valid", bus.ar_valid, 1);
                    check("ar_hold_addr", bus.ar_addr, prev_addr);
                end
                if (bus.ar_valid) begin
                    check("ar_extra", 32'(ar_idx < int'(m_size)), 1);
                    check("ar_credit", 32'((ar_idx - d_idx) < 4), 1);
                    e = m_base + 32'(ar_idx) * 32'(m_stride);
                    check("ar_addr", bus.ar_addr, e);
                end
                nd = 0;
                nb = m_busy;
                if (start && !m_busy && !m_done) begin
                    m_base = base; m_size = size; m_stride = stride;
                    ar_idx = 0; d_idx = 0; m_err = 0;
                    if (size == 16'd0) nd = 1; else nb = 1;
                end
                if (bus.ar_valid && bus.ar_ready) begin
                    if (ar_idx == 0) first_ar = bus.ar_addr;
                    last_ar = bus.ar_addr;
                    ar_idx++;
                end
                if (bus.r_valid && bus.r_resp != 2'b00) m_err = 1;
                if (bus.data_valid && bus.data_ready) begin
                    e = m_base + 32'(d_idx) * 32'(m_stride);
                    check("data", bus.data, e);
                    if (d_idx == 0) first_data = bus.data;
                    last_data = bus.data;
                    d_idx++;
                    if (d_idx == int'(m_size)) begin nd = 1; nb = 0; end
                end
                m_done = nd;
                m_busy = nb;
                prev_stall = bus.ar_valid && !bus.ar_ready;
                prev_addr  = bus.ar_addr;
            end
        end
    end

    task automatic start_xfer(input logic [31:0] b, input logic [15:0] s, input logic [15:0] st);
        @(posedge clk); #1;
        base = b; size = s; stride = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_ar_valid"}, bus.ar_valid, 0);
        check({tag, "_data_valid"}, bus.data_valid, 0);
        check({tag, "_ar_addr"}, bus.ar_addr, 32'h0);
        check({tag, "_data"}, bus.data, 32'h0);
        check({tag, "_r_ready"}, bus.r_ready, 1);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; base = '0; size = '0; stride = '0;
        bus.data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;

        // basic transfer, plus first-cycle timing after start
        d0 = done_cnt;
        start_xfer(32'h8000_0000, 16'd8, 16'd8);
        check("basic_busy_c1", busy, 1);
        check("basic_arv_c1", bus.ar_valid, 1);
        check("basic_addr_c1", bus.ar_addr, 32'h8000_0000);
        wait_done("basic");
        repeat (3) @(posedge clk);
        #1;
        check("basic_done_cnt", 32'(done_cnt - d0), 1);
        check("basic_words", 32'(d_idx), 8);
        check("basic_last_ar", last_ar, 32'h8000_0038);
        check("basic_last_data", last_data, 32'h8000_0038);
        check("basic_error", error, 0);

        // lane select: upper, lower, upper, lower
        start_xfer(32'h8000_0004, 16'd4, 16'd4);
        wait_done("lane");
        check("lane_first", first_data, 32'h8000_0004);
        check("lane_last", last_data, 32'h8000_0010);

        // backpressure: stall the consumer for 20 cycles
        bus.data_ready = 1'b0;
        start_xfer(32'h0000_1000, 16'd10, 16'd4);
        repeat (20) @(posedge clk);
        #1;
        check("bp_ar_count", 32'(ar_idx), 4);
        check("bp_ar_valid", bus.ar_valid, 0);
        check("bp_data_valid", bus.data_valid, 1);
        check("bp_head", bus.data, 32'h0000_1000);
        bus.data_ready = 1'b1;
        wait_done("bp");
        check("bp_words", 32'(d_idx), 10);
        check("bp_last", last_data, 32'h0000_1024);

        // zero size
        start_xfer(32'h0000_5000, 16'd0, 16'd4);
        check("zero_done_c1", done, 1);
        check("zero_busy_c1", busy, 0);
        check("zero_ar_valid", bus.ar_valid, 0);
        @(posedge clk); #1;

        // start while busy is ignored
        start_xfer(32'h0000_2000, 16'd6, 16'd8);
        repeat (2) @(posedge clk);
        #1;
        base = 32'h0000_9000; size = 16'd2; stride = 16'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        check("busy_start_words", 32'(d_idx), 6);
        check("busy_start_last", last_data, 32'h0000_2028);

        // error response on word 3 of 5, with random ready/gaps
        gap_mode = 1'b1; err_beat = 2;
        start_xfer(32'h0000_3000, 16'd5, 16'd4);
        wait_done("err");
        check("err_at_done", error, 1);
        check("err_words", 32'(d_idx), 5);
        check("err_last", last_data, 32'h0000_3010);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", error, 1);
        gap_mode = 1'b0; err_beat = -1;

        // address wrap; the start also clears the sticky error
        start_xfer(32'hFFFF_FFF8, 16'd3, 16'd8);
        check("wrap_err_clr", error, 0);
        wait_done("wrap");
        check("wrap_first_ar", first_ar, 32'hFFFF_FFF8);
        check("wrap_last_ar", last_ar, 32'h0000_0008);
        check("wrap_last_data", last_data, 32'h0000_0008);

        // reset in the middle of a transfer, then recover
        start_xfer(32'h0000_4000, 16'd8, 16'd4);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("midrst");
        rst = 1'b0;
        start_xfer(32'h0000_6000, 16'd2, 16'd4);
        wait_done("recover");
        check("recover_words", 32'(d_idx), 2);
        check("recover_last", last_data, 32'h0000_6004);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
